// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage: counts outstanding long-latency writes per
// register and raises the issue stall for RAW, WAW-behind-long and per-register-full hazards.
module reg_scoreboard #(
    parameter int REG_AW       = 5,
    parameter int MAX_PEND     = 3,
    parameter int NUM_WB_PORTS = 2,
    parameter int CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic                           issue_fire,
    input  logic                           flush,
    input  logic                           issue_long,
    input  logic                           issue_rd_write,
    input  logic [REG_AW-1:0]              issue_rd_addr,
    input  logic                           issue_rs1_read,
    input  logic [REG_AW-1:0]              issue_rs1_addr,
    input  logic                           issue_rs2_read,
    input  logic [REG_AW-1:0]              issue_rs2_addr,
    input  logic [NUM_WB_PORTS-1:0]        wb_valid,
    input  logic [NUM_WB_PORTS*REG_AW-1:0] wb_rd_addr,
    output logic [2**REG_AW-1:0]           busy_mask,
    output logic [REG_AW+$clog2(MAX_PEND+1)-1:0] pend_total,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic                           err_underflow
);

    localparam int NREG = 2**REG_AW;
    localparam int PW   = $clog2(MAX_PEND+1);
    localparam int RW   = $clog2(NUM_WB_PORTS+1);
    localparam int SW   = ((PW > RW) ? PW : RW) + 2;
    localparam int TW   = REG_AW + PW;

    logic [PW-1:0]   pend     [NREG];
    logic [PW-1:0]   pend_nxt [NREG];
    logic [PW-1:0]   eff      [NREG];
    logic [RW-1:0]   rel      [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] under;
    logic [NREG-1:0] busy_nxt;
    logic [TW-1:0]   total_nxt;
    logic            raw_haz;
    logic            waw_haz;
    logic            full_haz;

    // Per-register release count, including duplicate writebacks to one register.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            rel[r] = '0;
            inc[r] = 1'b0;
        end
        for (int r = 1; r < NREG; r++) begin
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (wb_valid[p] && (wb_rd_addr[p*REG_AW +: REG_AW] == REG_AW'(r)))
                    rel[r] = rel[r] + RW'(1);
            end
            inc[r] = issue_fire & ~flush & issue_long & issue_rd_write &
                     (issue_rd_addr == REG_AW'(r));
        end
    end

    // eff is what the hazard check sees: a same-cycle writeback already counts as done.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (SW'(pend[r]) > SW'(rel[r]))
                eff[r] = PW'(SW'(pend[r]) - SW'(rel[r]));
            else
                eff[r] = '0;
        end
    end

    always_comb begin
        raw_haz  = (issue_rs1_read && (issue_rs1_addr != '0) && (eff[issue_rs1_addr] != '0)) ||
                   (issue_rs2_read && (issue_rs2_addr != '0) && (eff[issue_rs2_addr] != '0));
        waw_haz  = issue_rd_write && !issue_long && (issue_rd_addr != '0) &&
                   (eff[issue_rd_addr] != '0);
        full_haz = issue_rd_write && issue_long && (issue_rd_addr != '0) &&
                   (eff[issue_rd_addr] == PW'(MAX_PEND));
        issue_ready = ~(raw_haz | waw_haz | full_haz);
    end

    // Saturation at MAX_PEND only matters when a fire ignores issue_ready.
    always_comb begin
        total_nxt = '0;
        busy_nxt  = '0;
        for (int r = 0; r < NREG; r++) begin
            under[r]    = 1'b0;
            pend_nxt[r] = '0;
            if (SW'(rel[r]) > SW'(pend[r]) + SW'(inc[r])) begin
                under[r] = 1'b1;
            end else if (SW'(pend[r]) + SW'(inc[r]) - SW'(rel[r]) > SW'(MAX_PEND)) begin
                pend_nxt[r] = PW'(MAX_PEND);
            end else begin
                pend_nxt[r] = PW'(SW'(pend[r]) + SW'(inc[r]) - SW'(rel[r]));
            end
            busy_nxt[r] = (pend_nxt[r] != '0);
            total_nxt   = total_nxt + TW'(pend_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int r = 0; r < NREG; r++)
                pend[r] <= '0;
            busy_mask     <= '0;
            pend_total    <= '0;
            stall_cnt     <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                pend[r] <= pend_nxt[r];
            busy_mask  <= busy_nxt;
            pend_total <= total_nxt;
            if (under != '0)
                err_underflow <= 1'b1;
            if (issue_valid && !flush && !issue_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a per-register count model checked every
// cycle, plus hand-computed expectations at each scenario step.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_b;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_fire;
    logic        flush;
    logic        issue_long;
    logic        issue_rd_write;
    logic [4:0]  issue_rd_addr;
    logic        issue_rs1_read;
    logic [4:0]  issue_rs1_addr;
    logic        issue_rs2_read;
    logic [4:0]  issue_rs2_addr;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd_addr;
    logic [31:0] busy_mask;
    logic [6:0]  pend_total;
    logic [15:0] stall_cnt;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    int pend_m [32];
    int stall_m = 0;
    bit err_m = 0;
    bit rdy_m;
    int nv, rl;

    reg_scoreboard dut (
        .clk(clk), .rst_b(rst_b),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_fire(issue_fire), .flush(flush),
        .issue_long(issue_long), .issue_rd_write(issue_rd_write),
        .issue_rd_addr(issue_rd_addr),
        .issue_rs1_read(issue_rs1_read), .issue_rs1_addr(issue_rs1_addr),
        .issue_rs2_read(issue_rs2_read), .issue_rs2_addr(issue_rs2_addr),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .busy_mask(busy_mask), .pend_total(pend_total),
        .stall_cnt(stall_cnt), .err_underflow(err_underflow)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_rel(input int a);
        int n = 0;
        for (int p = 0; p < 2; p++)
            if (wb_valid[p] && (int'(wb_rd_addr[p*5 +: 5]) == a)) n++;
        return n;
    endfunction

    function automatic int eff_m(input int a);
        int v;
        if (a == 0) return 0;
        v = pend_m[a] - n_rel(a);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit exp_ready();
        bit haz;
        haz = (issue_rs1_read && eff_m(int'(issue_rs1_addr)) > 0) ||
              (issue_rs2_read && eff_m(int'(issue_rs2_addr)) > 0) ||
              (issue_rd_write && !issue_long && eff_m(int'(issue_rd_addr)) > 0) ||
              (issue_rd_write && issue_long && eff_m(int'(issue_rd_addr)) == 3);
        return !haz;
    endfunction

    // Reference model: count bookkeeping from the scoreboard rules.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int r = 0; r < 32; r++) pend_m[r] = 0;
            stall_m = 0;
            err_m   = 0;
        end else begin
            rdy_m = exp_ready();
            if (issue_valid && !flush && !rdy_m && stall_m < 65535) stall_m++;
            for (int r = 1; r < 32; r++) begin
                rl = n_rel(r);
                nv = pend_m[r] - rl;
                if (issue_fire && !flush && issue_long && issue_rd_write && int'(issue_rd_addr) == r)
                    nv++;
                if (nv < 0) begin
                    err_m = 1;
                    nv = 0;
                end
                if (nv > 3) nv = 3;
                pend_m[r] = nv;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] bm;
        int tot;
        bm  = '0;
        tot = 0;
        for (int r = 1; r < 32; r++) begin
            if (pend_m[r] != 0) bm[r] = 1'b1;
            tot += pend_m[r];
        end
        chk("ready", issue_ready, exp_ready());
        chk("busy_mask", busy_mask, bm);
        chk("pend_total", pend_total, tot);
        chk("stall_cnt", stall_cnt, stall_m);
        chk("err_underflow", err_underflow, err_m);
        chk("protocol_fire_when_not_ready", issue_fire & ~issue_ready, 0);
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_fire = 0; flush = 0; issue_long = 0;
        issue_rd_write = 0; issue_rd_addr = 0;
        issue_rs1_read = 0; issue_rs1_addr = 0;
        issue_rs2_read = 0; issue_rs2_addr = 0;
        wb_valid = 0; wb_rd_addr = 0;
    endtask

    task automatic fire_long(input int rd);
        issue_valid = 1; issue_fire = 1; issue_long = 1;
        issue_rd_write = 1; issue_rd_addr = 5'(rd);
    endtask

    task automatic wb(input bit v0, input int a0, input bit v1, input int a1);
        wb_valid   = {v1, v0};
        wb_rd_addr = {5'(a1), 5'(a0)};
    endtask

    initial begin
        rst_b = 1;
        idle();
        #1 rst_b = 0;
        cyc(2);
        chk("rst_busy", busy_mask, 0);
        chk("rst_total", pend_total, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_ready", issue_ready, 1);
        rst_b = 1;

        // Long load to x5, then a dependent op stalls until the writeback.
        fire_long(5);
        #1 chk("x5_first_ready", issue_ready, 1);
        cyc();
        idle();
        issue_valid = 1; issue_rs1_read = 1; issue_rs1_addr = 5;
        #1;
        chk("x5_busy", busy_mask, 32'h20);
        chk("x5_total", pend_total, 1);
        chk("x5_raw_ready", issue_ready, 0);
        cyc(3);
        chk("x5_stall3", stall_cnt, 3);
        wb(1, 5, 0, 0);
        #1 chk("x5_zero_bubble", issue_ready, 1);
        issue_fire = 1;
        cyc();
        idle();
        #1;
        chk("x5_released", pend_total, 0);
        chk("x5_busy_clr", busy_mask, 0);
        chk("x5_stall_hold", stall_cnt, 3);

        // Fill x7 to MAX_PEND, fourth write gated until a same-cycle release.
        fire_long(7);
        cyc(3);
        idle();
        issue_valid = 1; issue_long = 1; issue_rd_write = 1; issue_rd_addr = 7;
        #1;
        chk("x7_total3", pend_total, 3);
        chk("x7_busy", busy_mask, 32'h80);
        chk("x7_full_ready", issue_ready, 0);
        wb(0, 0, 1, 7);
        #1 chk("x7_release_ready", issue_ready, 1);
        issue_fire = 1;
        cyc();
        idle();
        #1 chk("x7_still3", pend_total, 3);
        wb(1, 7, 1, 7);
        cyc();
        wb(1, 7, 0, 0);
        cyc();
        idle();
        #1 chk("x7_drained", pend_total, 0);

        // Simultaneous increment and release, then double release.
        fire_long(9);
        cyc();
        wb(1, 9, 0, 0);
        cyc();
        idle();
        #1;
        chk("x9_net_same", pend_total, 1);
        chk("x9_busy", busy_mask, 32'h200);
        fire_long(9);
        cyc();
        idle();
        #1 chk("x9_two", pend_total, 2);
        wb(1, 9, 1, 9);
        cyc();
        idle();
        #1;
        chk("x9_double_release", pend_total, 0);
        chk("x9_no_err", err_underflow, 0);

        // WAW-short and x0 exemptions.
        fire_long(3);
        cyc();
        idle();
        issue_valid = 1; issue_rd_write = 1; issue_rd_addr = 3;
        #1 chk("waw_short_ready", issue_ready, 0);
        issue_rd_addr = 0; issue_rs1_read = 1; issue_rs2_read = 1;
        #1 chk("x0_ready", issue_ready, 1);
        issue_long = 1; issue_fire = 1;
        cyc();
        idle();
        #1;
        chk("x0_not_tracked", pend_total, 1);
        chk("x3_busy", busy_mask, 32'h8);
        wb(1, 3, 0, 0);
        cyc();
        idle();

        // Underflow is sticky; flush blocks both increment and stall counting.
        wb(1, 4, 0, 0);
        cyc();
        idle();
        #1;
        chk("uf_set", err_underflow, 1);
        chk("uf_total", pend_total, 0);
        cyc(3);
        chk("uf_sticky", err_underflow, 1);
        fire_long(6);
        flush = 1;
        cyc();
        idle();
        #1;
        chk("flush_no_inc", pend_total, 0);
        chk("flush_stall_hold", stall_cnt, 3);
        fire_long(10);
        cyc();
        idle();
        issue_valid = 1; flush = 1; issue_rs1_read = 1; issue_rs1_addr = 10;
        cyc(2);
        chk("flush_stall_none", stall_cnt, 3);
        flush = 0;
        cyc();
        chk("stall_after_flush", stall_cnt, 4);
        idle();
        wb(1, 10, 0, 0);
        cyc();
        idle();

        // Async reset in the middle of a stall, between clock edges.
        fire_long(5);
        cyc(2);
        idle();
        issue_valid = 1; issue_rs1_read = 1; issue_rs1_addr = 5;
        cyc(2);
        chk("pre_rst_total", pend_total, 2);
        chk("pre_rst_stall", stall_cnt, 6);
        #2 rst_b = 0;
        #1;
        chk("async_busy", busy_mask, 0);
        chk("async_total", pend_total, 0);
        chk("async_stall", stall_cnt, 0);
        chk("async_err", err_underflow, 0);
        chk("async_ready", issue_ready, 1);
        cyc();
        rst_b = 1;
        idle();

        // Long stall saturates the counter.
        fire_long(5);
        cyc();
        idle();
        issue_valid = 1; issue_rs1_read = 1; issue_rs1_addr = 5;
        cyc(65540);
        chk("stall_saturated", stall_cnt, 16'hFFFF);
        idle();
        wb(1, 5, 0, 0);
        cyc();
        idle();
        cyc(2);
        chk("final_total", pend_total, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register scoreboard for the ID stage.
- Tracks outstanding writes from long-latency units (loads past MEM, divider, future FPU) that the forwarding network cannot cover. Supports multiple writeback ports and multiple in-flight writes per register.
- Generates the issue stall and replaces the fixed single-load-in-EX/MEM stall check.
- Sits beside the decoder. ID drives the issue interface; each long-latency unit drives one writeback port.

Parameters:
REG_AW, 5, register address width; tracked registers 1..2**REG_AW-1 (x0 never tracked)
MAX_PEND, 3, max outstanding long writes per register (>=1)
NUM_WB_PORTS, 2, number of long-latency writeback ports (>=1)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
issue_valid  in  1  ID holds a valid decoded instruction
issue_ready  out  1  instruction may leave ID this cycle (no hazard)
issue_fire  in  1  instruction actually advanced (issue_valid & issue_ready & downstream ready)
flush  in  1  downstream flush; the instruction in ID is killed
issue_long  in  1  instruction targets a long-latency unit
issue_rd_write  in  1  instruction writes rd
issue_rd_addr  in  REG_AW  destination register
issue_rs1_read  in  1  rs1 is used
issue_rs1_addr  in  REG_AW  rs1 address
issue_rs2_read  in  1  rs2 is used
issue_rs2_addr  in  REG_AW  rs2 address
wb_valid  in  NUM_WB_PORTS  per-port long-latency writeback strobe
wb_rd_addr  in  NUM_WB_PORTS*REG_AW  packed writeback addresses; port i at bits [i*REG_AW +: REG_AW]
busy_mask  out  2**REG_AW  bit r = 1 when pend[r] != 0; bit 0 is always 0
pend_total  out  REG_AW+$clog2(MAX_PEND+1)  sum of all pending counts
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles
err_underflow  out  1  sticky: writeback seen for a register with pend == 0

Behaviour:
- State: one counter pend[r] per register, width $clog2(MAX_PEND+1). Async reset: all pend = 0, stall_cnt = 0, err_underflow = 0.
- Outputs after reset: issue_ready = 1 (combinational), busy_mask = 0, pend_total = 0.
- rel[r]: number of wb ports with wb_valid[i] and wb_rd_addr[i] == r, for r != 0. Duplicates count individually.
- eff[r] = pend[r] - rel[r], floored at 0. It is the count as seen by the hazard check, so a same-cycle writeback releases a register with zero bubble.
- Hazards: each term applies only when the register address != 0.
  - RAW: issue_rs1_read & eff[rs1] != 0, or the same for rs2.
  - WAW-short: issue_rd_write & ~issue_long & eff[rd] != 0. A short write must not be overtaken by an older long write.
  - FULL: issue_rd_write & issue_long & eff[rd] == MAX_PEND.
- issue_ready = ~(RAW | WAW-short | FULL). It is purely combinational and independent of flush.
- inc[r] = issue_fire & ~flush & issue_long & issue_rd_write & (rd == r) & (r != 0).
- Next-state value is pend[r] + inc[r] - rel[r], floored at 0:
  - Increment and release of the same register in one cycle leave it net unchanged.
  - Two ports releasing one register subtract 2.
- Underflow: if rel[r] > pend[r] + inc[r], set err_underflow (sticky until reset) and clamp pend[r] at 0.
- issue_fire while issue_ready = 0 is a protocol violation: the increment is still applied but saturates at MAX_PEND. A bench assertion flags it.
- Each long unit completes writes to the same rd in issue order. Long ops are past the flush point once issued, so flush never decrements pend.
- stall_cnt increments when issue_valid & ~flush & ~issue_ready, and saturates at 2**CNT_W-1.
- busy_mask and pend_total are registered views of the current pend; they do not use eff.
- Reset asserted mid-operation clears all state immediately. Writebacks that arrive after reset deassertion set err_underflow; software or the bench treats this as expected after a reset during traffic.

Test Plan:
- Reset, then long load to x5 fires: next cycle pend[5] = 1, busy_mask = 0x20, pend_total = 1. Add rs1 = x5 with issue_valid: issue_ready = 0, stall_cnt counts 1, 2, 3 until wb_valid[0] with addr 5. In the writeback cycle issue_ready = 1 (zero-bubble release), then pend[5] = 0.
- MAX_PEND = 3: three back-to-back long writes to x7 fire; the fourth long write to x7 sees issue_ready = 0. Port 1 writeback to x7 in the same cycle makes issue_ready = 1; the fourth fires and pend[7] stays 3.
- Simultaneous events: fire a long write to x9 while port 0 writes back x9 (pend[9] = 1) -> pend[9] remains 1. Both ports write back x9 with pend = 2 -> pend = 0 in one cycle.
- WAW-short: pend[3] = 1, then a short ALU op with rd = x3 -> issue_ready = 0. An op with rd = x0 or rs = x0 is never stalled, even with busy registers present.
- Underflow and flush: wb to x4 with pend[4] = 0 -> err_underflow = 1 and stays set, pend[4] = 0. A long issue_fire with flush = 1 -> no increment, and stall_cnt does not increment.
- Async reset pulse mid-stall with pend[5] = 2 -> all outputs return to reset values with no clock edge. A 2**CNT_W-cycle stall leaves stall_cnt saturated at 0xFFFF.
